// File: rtl/mario_sound_cmd.sv
// Main-CPU sound command interface: FWFT command FIFO, digital level bits and
// stretched analog trigger pulses driving the sound subsystem inputs.
module mario_sound_cmd #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PULSE_LEN  = 1024,
    parameter int unsigned PCNT_W     = 11
) (
    input  logic       I_CLK_12M,
    input  logic       I_RST,
    input  logic       I_CPU_WR,
    input  logic [1:0] I_CPU_ADDR,
    input  logic [7:0] I_CPU_DATA,
    input  logic       I_SND_RD,
    output logic [7:0] O_SND_DATA,
    output logic [9:0] O_SND_CTRL,
    output logic       O_SND_PEND,
    output logic       O_FIFO_FULL,
    output logic       O_OVF
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NTRIG = 3;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [CNT_W-1:0]  count, count_nx;
    logic              push, pop, full, accept;
    logic [7:0]        data_nx;
    logic              ovf_nx;
    logic [9:0]        ctrl_nx;
    logic [PCNT_W-1:0] pcnt [NTRIG];
    logic [PCNT_W-1:0] pcnt_nx [NTRIG];

    // Next-state for FIFO bookkeeping, head byte, overflow flag and pulses
    always_comb begin
        full      = (count == CNT_W'(FIFO_DEPTH));
        push      = I_CPU_WR && (I_CPU_ADDR == 2'd0);
        pop       = I_SND_RD && (count != '0);
        accept    = push && (!full || pop);
        wr_ptr_nx = accept ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nx = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nx  = count + CNT_W'(accept) - CNT_W'(pop);

        // Empty FIFO keeps showing the last byte, like the original latch
        data_nx = O_SND_DATA;
        if (count_nx != '0) begin
            if ((count == '0) || (pop && (count == CNT_W'(1))))
                data_nx = I_CPU_DATA;
            else
                data_nx = mem[rd_ptr_nx];
        end

        ovf_nx = O_OVF;
        if (I_CPU_WR && (I_CPU_ADDR == 2'd3))
            ovf_nx = 1'b0;
        if (push && !accept)
            ovf_nx = 1'b1;

        ctrl_nx = O_SND_CTRL;
        if (I_CPU_WR && (I_CPU_ADDR == 2'd1))
            ctrl_nx[6:0] = I_CPU_DATA[6:0];

        for (int unsigned i = 0; i < NTRIG; i++) begin
            pcnt_nx[i] = pcnt[i];
            if (pcnt[i] != '0)
                pcnt_nx[i] = pcnt[i] - PCNT_W'(1);
            if (I_CPU_WR && (I_CPU_ADDR == 2'd2) && I_CPU_DATA[i])
                pcnt_nx[i] = PCNT_W'(PULSE_LEN);
            ctrl_nx[7+i] = (pcnt_nx[i] != '0);
        end
    end

    always_ff @(posedge I_CLK_12M or posedge I_RST) begin
        if (I_RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            O_SND_DATA  <= '0;
            O_SND_CTRL  <= '0;
            O_SND_PEND  <= 1'b0;
            O_FIFO_FULL <= 1'b0;
            O_OVF       <= 1'b0;
            for (int unsigned i = 0; i < NTRIG; i++)
                pcnt[i] <= '0;
        end else begin
            wr_ptr      <= wr_ptr_nx;
            rd_ptr      <= rd_ptr_nx;
            count       <= count_nx;
            O_SND_DATA  <= data_nx;
            O_SND_CTRL  <= ctrl_nx;
            O_SND_PEND  <= (count_nx != '0);
            O_FIFO_FULL <= (count_nx == CNT_W'(FIFO_DEPTH));
            O_OVF       <= ovf_nx;
            for (int unsigned i = 0; i < NTRIG; i++)
                pcnt[i] <= pcnt_nx[i];
        end
    end

    // Storage needs no reset; the pointers define which entries are valid
    always_ff @(posedge I_CLK_12M) begin
        if (accept)
            mem[wr_ptr] <= I_CPU_DATA;
    end

endmodule

// File: tb/tb_mario_sound_cmd.sv
// Bench for mario_sound_cmd: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mario_sound_cmd;

    localparam int DEPTH = 4;
    localparam int PLEN  = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [1:0] cpu_addr = 2'd0;
    logic [7:0] cpu_data = 8'd0;
    logic       snd_rd = 1'b0;
    logic [7:0] snd_data;
    logic [9:0] snd_ctrl;
    logic       snd_pend, fifo_full, ovf;

    mario_sound_cmd #(.FIFO_DEPTH(DEPTH), .PULSE_LEN(PLEN), .PCNT_W(11)) dut (
        .I_CLK_12M  (clk),
        .I_RST      (rst),
        .I_CPU_WR   (cpu_wr),
        .I_CPU_ADDR (cpu_addr),
        .I_CPU_DATA (cpu_data),
        .I_SND_RD   (snd_rd),
        .O_SND_DATA (snd_data),
        .O_SND_CTRL (snd_ctrl),
        .O_SND_PEND (snd_pend),
        .O_FIFO_FULL(fifo_full),
        .O_OVF      (ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit cmp_en  = 1'b0;

    // Reference model: pending commands, last shown byte, flags, pulse end cycles
    logic [7:0] q[$];
    logic [7:0] m_shown;
    bit         m_ovf;
    logic [6:0] m_level;
    int         m_trig_end [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_shown = 8'd0;
        m_ovf   = 1'b0;
        m_level = 7'd0;
        for (int i = 0; i < 3; i++) m_trig_end[i] = -1;
    endtask

    task automatic model_step(input bit wr, input bit [1:0] addr, input bit [7:0] data, input bit rd);
        bit was_full;
        was_full = (q.size() == DEPTH);
        if (rd && q.size() != 0) void'(q.pop_front());
        if (wr) begin
            case (addr)
                2'd0: if (was_full && !rd) m_ovf = 1'b1; else q.push_back(data);
                2'd1: m_level = data[6:0];
                2'd2: for (int i = 0; i < 3; i++) if (data[i]) m_trig_end[i] = cyc + PLEN;
                default: m_ovf = 1'b0;
            endcase
        end
        if (q.size() != 0) m_shown = q[0];
    endtask

    function automatic logic [9:0] exp_ctrl();
        logic [9:0] c;
        c[6:0] = m_level;
        for (int i = 0; i < 3; i++) c[7+i] = (cyc <= m_trig_end[i]);
        return c;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("data", 32'(snd_data), 32'(m_shown));
            chk("ctrl", 32'(snd_ctrl), 32'(exp_ctrl()));
            chk("pend", 32'(snd_pend), 32'(q.size() != 0));
            chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
            chk("ovf",  32'(ovf), 32'(m_ovf));
        end
    end

    task automatic step(input bit wr, input bit [1:0] addr, input bit [7:0] data, input bit rd);
        cpu_wr = wr; cpu_addr = addr; cpu_data = data; snd_rd = rd;
        @(posedge clk);
        if (!rst) model_step(wr, addr, data, rd);
        cyc++;
        @(negedge clk);
        cpu_wr = 1'b0; snd_rd = 1'b0;
    endtask

    task automatic idle_until(input int target);
        while (cyc < target) step(1'b0, 2'd0, 8'd0, 1'b0);
    endtask

    initial begin
        int t;
        model_reset();
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_data", 32'(snd_data), 32'h0);
        chk("rst_ctrl", 32'(snd_ctrl), 32'h0);
        chk("rst_pend", 32'(snd_pend), 32'h0);

        // 1: single push then pop; data holds after empty
        step(1'b1, 2'd0, 8'h12, 1'b0);
        chk("t1_pend", 32'(snd_pend), 32'h1);
        chk("t1_data", 32'(snd_data), 32'h12);
        step(1'b0, 2'd0, 8'h00, 1'b1);
        chk("t1_pend_pop", 32'(snd_pend), 32'h0);
        chk("t1_hold", 32'(snd_data), 32'h12);

        // 2: overfill, ordered readout, overflow clear
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'd0, 8'(8'hA0 + i), 1'b0);
            if (i == 3) begin
                chk("t2_full", 32'(fifo_full), 32'h1);
                chk("t2_noovf", 32'(ovf), 32'h0);
            end
        end
        chk("t2_ovf", 32'(ovf), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", 32'(snd_data), 32'(8'hA0 + i));
            step(1'b0, 2'd0, 8'h00, 1'b1);
        end
        chk("t2_empty", 32'(snd_pend), 32'h0);
        step(1'b1, 2'd3, 8'h00, 1'b0);
        chk("t2_clr", 32'(ovf), 32'h0);

        // 3: push and pop together while full
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 8'(8'h60 + i), 1'b0);
        step(1'b1, 2'd0, 8'h55, 1'b1);
        chk("t3_full", 32'(fifo_full), 32'h1);
        chk("t3_ovf", 32'(ovf), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", 32'(snd_data), (i == 3) ? 32'h55 : 32'(8'h61 + i));
            step(1'b0, 2'd0, 8'h00, 1'b1);
        end

        // 4: trigger pulses with retrigger
        t = cyc;
        step(1'b1, 2'd2, 8'h05, 1'b0);
        chk("t4_start", 32'(snd_ctrl[9:7]), 32'h5);
        idle_until(t + 500);
        step(1'b1, 2'd2, 8'h01, 1'b0);
        idle_until(t + PLEN);
        chk("t4_last", 32'(snd_ctrl[9:7]), 32'h5);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        chk("t4_end9", 32'(snd_ctrl[9:7]), 32'h1);
        idle_until(t + 500 + PLEN);
        chk("t4_ext", 32'(snd_ctrl[7]), 32'h1);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        chk("t4_ext_end", 32'(snd_ctrl[7]), 32'h0);

        // 5: level bits, then async reset mid-pulse with queued entries
        step(1'b1, 2'd1, 8'hFF, 1'b0);
        chk("t5_level", 32'(snd_ctrl[6:0]), 32'h7F);
        step(1'b1, 2'd2, 8'h02, 1'b0);
        step(1'b1, 2'd0, 8'h11, 1'b0);
        step(1'b1, 2'd0, 8'h22, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("t5_rst_ctrl", 32'(snd_ctrl), 32'h0);
        chk("t5_rst_data", 32'(snd_data), 32'h0);
        chk("t5_rst_pend", 32'(snd_pend), 32'h0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0);
        rst = 1'b0;
        step(1'b0, 2'd0, 8'h00, 1'b0);
        chk("t5_post_pend", 32'(snd_pend), 32'h0);

        // 6: pop on empty coincident with push
        step(1'b1, 2'd0, 8'h3C, 1'b1);
        chk("t6_data", 32'(snd_data), 32'h3C);
        chk("t6_pend", 32'(snd_pend), 32'h1);
        chk("t6_full", 32'(fifo_full), 32'h0);
        step(1'b0, 2'd0, 8'h00, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 9) < 5), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 4));
        end

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mario_sound_cmd.md
Name: mario_sound_cmd

Overview:
- Main-CPU-side sound command interface. It produces the sound-command byte and the 10-bit control vector consumed by the sound subsystem's data/control inputs.
- Buffers CPU command writes in a small FWFT FIFO so back-to-back writes are not lost.
- Holds digital-sound level control bits.
- Stretches analog-sample trigger writes (Mario run, Luigi run, skid) into fixed-length pulses.
- Sits between main-CPU address decode and the sound top level, in the 12 MHz domain.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; must be a power of 2, ≥2.
- PULSE_LEN, 1024: trigger pulse length in I_CLK_12M cycles; ≥1.
- PCNT_W, 11: pulse counter width; must satisfy 2^PCNT_W > PULSE_LEN.

Ports:
- I_CLK_12M  in  1  sole clock.
- I_RST  in  1  asynchronous, active-high reset.
- I_CPU_WR  in  1  single-cycle write strobe, already qualified by CPU decode.
- I_CPU_ADDR  in  2  register select.
- I_CPU_DATA  in  8  write data.
- I_SND_RD  in  1  single-cycle pop strobe from sound-CPU latch read.
- O_SND_DATA  out  8  command byte to sound subsystem.
- O_SND_CTRL  out  10  [6:0] digital level bits, [9:7] analog trigger pulses.
- O_SND_PEND  out  1  FIFO non-empty (sound-CPU interrupt request).
- O_FIFO_FULL  out  1  FIFO full.
- O_OVF  out  1  sticky overflow flag.

Behaviour:
- All outputs are registered. Reset (async assert, sync-to-clock deassert) forces every output to 0, empties the FIFO, and clears the pointers and all pulse counters.
- Register map. Every action happens only when I_CPU_WR=1; otherwise nothing changes.
  - ADDR 0: push I_CPU_DATA into the FIFO.
  - ADDR 1: O_SND_CTRL[6:0] <= I_CPU_DATA[6:0]. Visible the next cycle. Bit 7 is ignored.
  - ADDR 2: for each i in 0..2, if I_CPU_DATA[i]=1, load trigger counter i with PULSE_LEN. A 0 bit leaves counter i untouched.
  - ADDR 3: clear O_OVF.
- FIFO behaviour:
  - First-word-fall-through: O_SND_DATA shows the head entry when non-empty.
  - When empty, O_SND_DATA holds the last value shown; it does not go to 0, so it emulates the original latch.
  - Push at cycle t: O_SND_PEND and O_SND_DATA (if the FIFO was empty) update at t+1.
  - Pop (I_SND_RD=1 while non-empty) at t: next head, or hold if now empty, appears at t+1.
  - Pop while empty: ignored, no pointer movement.
- FIFO boundary cases:
  - Push while full, no pop: data dropped, O_OVF <= 1 (sticky until ADDR 3 write or reset), pointers unchanged.
  - Push and pop in the same cycle while full: both are accepted, the count is unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push is accepted, the pop is ignored, count becomes 1.
  - ADDR 3 clear and overflow in the same cycle: set wins, O_OVF=1.
- O_FIFO_FULL = (count == FIFO_DEPTH). O_SND_PEND = (count != 0). The count register is log2(FIFO_DEPTH)+1 bits wide.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- Trigger counters:
  - Each counter decrements by 1 per clock while nonzero and saturates at 0.
  - O_SND_CTRL[7+i] = 1 exactly while counter i is nonzero, registered. A write at cycle t gives high from t+1 through t+PULSE_LEN, low at t+PULSE_LEN+1.
  - A retrigger while active reloads PULSE_LEN; the pulse is extended with no low glitch.
- Reset mid-operation: the FIFO contents are discarded, pulses terminate immediately, and level bits return to 0.

Test Plan:
1. Reset, then write ADDR0=0x12 at t → O_SND_PEND=1 and O_SND_DATA=0x12 at t+1. Pulse I_SND_RD → O_SND_PEND=0, O_SND_DATA holds 0x12.
2. Write 0xA0..0xA4 back-to-back, FIFO_DEPTH=4 → O_FIFO_FULL=1 after the 4th write, O_OVF=1 after the 5th. Pops return 0xA0..0xA3 in order. ADDR3 write → O_OVF=0.
3. Fill the FIFO to full, then assert push (0x55) and pop in the same cycle → count stays 4, O_OVF=0, 0x55 is the last entry read out.
4. Write ADDR2=0x05 at t (PULSE_LEN=1024) → O_SND_CTRL[7] and [9] high for cycles t+1..t+1024, [8] stays 0. Rewrite 0x01 at t+500 → [7] high through t+1524.
5. Write ADDR1=0xFF → O_SND_CTRL[6:0]=0x7F next cycle, [9:7] unaffected. Assert I_RST mid-pulse with 2 FIFO entries → all outputs 0 asynchronously, O_SND_PEND=0 after release.
6. Pop on an empty FIFO coincident with a push of 0x3C → count=1, O_SND_DATA=0x3C, O_SND_PEND=1.
